// File: rtl/mux_arb_2ch_32bit.sv
// Two-requester burst arbiter driving the shared 2:1 datapath mux, with one registered output stage.
// Optional build macro MUX_ARB_FIXED_PRIO_EN: requester A always wins simultaneous requests.
module mux_arb_2ch_32bit #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  a_last,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  b_last,
    output logic                  b_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  o_ready,
    output logic                  sel,
    output logic                  busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t          state, state_nxt;
    logic            last_grant;    // 0 = A, 1 = B
    logic [CW-1:0]   beat_cnt;
    logic            out_free, a_acc, b_acc, acc, acc_last, cap_hit, rel, arb;
    logic            cand_a, cand_b, win_b;

    assign out_free = !o_valid || o_ready;
    assign a_acc    = a_valid && a_ready;
    assign b_acc    = b_valid && b_ready;
    assign acc      = a_acc || b_acc;
    assign acc_last = a_acc ? a_last : b_last;
    assign cap_hit  = (beat_cnt == CW'(MAX_BURST - 1));
    assign rel      = acc && (acc_last || cap_hit);
    assign arb      = (state == IDLE) || rel;

    // The releasing requester's valid belongs to the beat just consumed, so it
    // cannot re-win on its own release edge.
    assign cand_a = a_valid && (state != GNT_A);
    assign cand_b = b_valid && (state != GNT_B);

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign win_b = cand_b && !cand_a;
`else
    assign win_b = cand_b && (!cand_a || !last_grant);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, GNT_A, GNT_B: begin
                if (arb) begin
                    if (cand_a || cand_b) state_nxt = win_b ? GNT_B : GNT_A;
                    else                  state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        busy    = 1'b0;
        case (state)
            GNT_A: begin a_ready = out_free; busy = 1'b1; end
            GNT_B: begin b_ready = out_free; busy = 1'b1; end
            default: ;
        endcase
    end

    // Grant bookkeeping; sel holds its last grant through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            if (state_nxt != IDLE) sel <= (state_nxt == GNT_B);
            if (rel)               last_grant <= (state == GNT_B);
            if (rel)               beat_cnt <= '0;
            else if (acc)          beat_cnt <= beat_cnt + CW'(1);
        end
    end

    // Registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (acc) begin
            o_valid <= 1'b1;
            o_data  <= sel ? b_data : a_data;
            o_last  <= acc_last;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_2ch_32bit.sv
// Directed bench for mux_arb_2ch_32bit: per-cycle vector table plus streamed corner-case sequences.
module tb_mux_arb_2ch_32bit;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        a_valid = 0, a_last = 0, b_valid = 0, b_last = 0, o_ready = 1;
    logic [31:0] a_data = 0, b_data = 0;
    logic        a_ready, b_ready, o_valid, o_last, sel, busy;
    logic [31:0] o_data;

    int checks = 0, errors = 0;

    mux_arb_2ch_32bit #(.DATA_WIDTH(32), .MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_ready(o_ready),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic av; logic [31:0] ad; logic al;
        logic bv; logic [31:0] bd; logic bl;
        logic ov; logic [31:0] od; logic ol;
        logic s;  logic bz; logic ar; logic br;
    } vec_t;

    vec_t vecs[13];

    logic [32:0] qa[$], qb[$], qo[$];
    int          to[$];
    logic        so[$];

    function automatic vec_t mk(logic av, logic [31:0] ad, logic al, logic bv, logic [31:0] bd,
                                logic bl, logic ov, logic [31:0] od, logic ol, logic s,
                                logic bz, logic ar, logic br);
        vec_t v;
        v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl;
        v.ov = ov; v.od = od; v.ol = ol; v.s = s; v.bz = bz; v.ar = ar; v.br = br;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Streams qa/qb into the DUT (A held off until a_start), collects output beats into qo.
    task automatic run(int ncyc, int a_start, logic [63:0] stall);
        bit          ahs = 0, bhs = 0;
        logic [31:0] held = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (ahs) void'(qa.pop_front());
            if (bhs) void'(qb.pop_front());
            a_valid = (c >= a_start) && (qa.size() > 0);
            a_data  = a_valid ? qa[0][31:0] : 32'h0;
            a_last  = a_valid ? qa[0][32] : 1'b0;
            b_valid = qb.size() > 0;
            b_data  = b_valid ? qb[0][31:0] : 32'h0;
            b_last  = b_valid ? qb[0][32] : 1'b0;
            o_ready = !stall[c];
            #1;
            ahs = a_valid && a_ready;
            bhs = b_valid && b_ready;
            if (ahs || bhs) begin
                so.push_back(sel);
                chk("sel_matches_grant", {63'h0, sel}, {63'h0, bhs});
            end
            if (o_valid && o_ready) begin
                qo.push_back({o_last, o_data});
                to.push_back(c);
            end
            if (stall[c]) begin
                chk("stall_a_ready", {63'h0, a_ready}, 64'h0);
                chk("stall_o_valid", {63'h0, o_valid}, 64'h1);
                if (c > 0 && stall[c-1]) chk("stall_hold", {32'h0, o_data}, {32'h0, held});
                else held = o_data;
            end
        end
        @(negedge clk);
        a_valid = 0; b_valid = 0; a_last = 0; b_last = 0; o_ready = 1;
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); qo.delete(); to.delete(); so.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] exp2[4];

        // Round 1 both valid from reset (A wins), then the 3-beat A-only burst
        vecs[0]  = mk(1, 32'hA1, 0, 1, 32'hB1, 0,  0, 0, 0,         0, 0, 0, 0);
        vecs[1]  = mk(1, 32'hA1, 0, 1, 32'hB1, 0,  0, 0, 0,         0, 1, 1, 0);
        vecs[2]  = mk(1, 32'hA2, 1, 1, 32'hB1, 0,  1, 32'hA1, 0,    0, 1, 1, 0);
        vecs[3]  = mk(0, 0,      0, 1, 32'hB1, 0,  1, 32'hA2, 1,    1, 1, 0, 1);
        vecs[4]  = mk(0, 0,      0, 1, 32'hB2, 1,  1, 32'hB1, 0,    1, 1, 0, 1);
        vecs[5]  = mk(0, 0,      0, 0, 0,      0,  1, 32'hB2, 1,    1, 0, 0, 0);
        vecs[6]  = mk(0, 0,      0, 0, 0,      0,  0, 0, 0,         1, 0, 0, 0);
        vecs[7]  = mk(1, 32'h11, 0, 0, 0,      0,  0, 0, 0,         1, 0, 0, 0);
        vecs[8]  = mk(1, 32'h11, 0, 0, 0,      0,  0, 0, 0,         0, 1, 1, 0);
        vecs[9]  = mk(1, 32'h22, 0, 0, 0,      0,  1, 32'h11, 0,    0, 1, 1, 0);
        vecs[10] = mk(1, 32'h33, 1, 0, 0,      0,  1, 32'h22, 0,    0, 1, 1, 0);
        vecs[11] = mk(0, 0,      0, 0, 0,      0,  1, 32'h33, 1,    0, 0, 0, 0);
        vecs[12] = mk(0, 0,      0, 0, 0,      0,  0, 0, 0,         0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset_outputs", {57'h0, o_valid, o_last, sel, busy, a_ready, b_ready, 1'b0},
            64'h0);
        chk("reset_o_data", {32'h0, o_data}, 64'h0);
        chk("reset_beat_cnt", {59'h0, dut.beat_cnt}, 64'h0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a_valid = vecs[i].av; a_data = vecs[i].ad; a_last = vecs[i].al;
            b_valid = vecs[i].bv; b_data = vecs[i].bd; b_last = vecs[i].bl;
            o_ready = 1;
            #1;
            chk($sformatf("vec%0d", i),
                {25'h0, o_valid, vecs[i].ov ? o_data : 32'h0, vecs[i].ov ? o_last : 1'b0,
                 sel, busy, a_ready, b_ready},
                {25'h0, vecs[i].ov, vecs[i].ov ? vecs[i].od : 32'h0, vecs[i].ov ? vecs[i].ol : 1'b0,
                 vecs[i].s, vecs[i].bz, vecs[i].ar, vecs[i].br});
        end

        // Round 2: A was granted last, so round-robin serves B first
        clear_q();
        qa = '{{1'b0, 32'hA3}, {1'b1, 32'hA4}};
        qb = '{{1'b0, 32'hB3}, {1'b1, 32'hB4}};
`ifdef MUX_ARB_FIXED_PRIO_EN
        exp2 = '{{1'b0, 32'hA3}, {1'b1, 32'hA4}, {1'b0, 32'hB3}, {1'b1, 32'hB4}};
`else
        exp2 = '{{1'b0, 32'hB3}, {1'b1, 32'hB4}, {1'b0, 32'hA3}, {1'b1, 32'hA4}};
`endif
        run(10, 0, 64'h0);
        chk("round2_count", 64'(qo.size()), 64'd4);
        for (int i = 0; i < 4 && i < qo.size(); i++)
            chk($sformatf("round2_beat%0d", i), {31'h0, qo[i]}, {31'h0, exp2[i]});
        if (qo.size() == 4) chk("round2_no_bubble", 64'(to[3] - to[0]), 64'd3);

        // Burst cap: B streams 20 beats with no last while A waits
        clear_q();
        for (int i = 0; i < 20; i++) qb.push_back({1'b0, 32'hB00 + 32'(i)});
        qa.push_back({1'b1, 32'hAA});
        run(30, 2, 64'h0);
        chk("cap_count", 64'(qo.size()), 64'd21);
        for (int i = 0; i < 21 && i < qo.size(); i++)
            chk($sformatf("cap_beat%0d", i), {31'h0, qo[i]},
                i < 16 ? {31'h0, 1'b0, 32'hB00 + 32'(i)} :
                i == 16 ? {31'h0, 1'b1, 32'hAA} : {31'h0, 1'b0, 32'hB00 + 32'(i - 1)});
        if (qo.size() > 16) chk("cap_16th_last", {63'h0, qo[15][32]}, 64'h0);
        if (so.size() > 16) chk("cap_sel_after16", {62'h0, so[15], so[16]}, 64'h2);
        chk("cap_hold_grant", {62'h0, busy, sel}, 64'h3);

        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;

        // Output stall mid-burst for three cycles
        clear_q();
        for (int i = 1; i <= 5; i++) qa.push_back({i == 5, 32'hC0 + 32'(i)});
        run(14, 0, 64'h38);
        chk("stall_count", 64'(qo.size()), 64'd5);
        for (int i = 0; i < 5 && i < qo.size(); i++)
            chk($sformatf("stall_beat%0d", i), {31'h0, qo[i]}, {31'h0, i == 4, 32'hC1 + 32'(i)});

        // Asynchronous reset during a B burst with a beat in flight
        clear_q();
        for (int i = 0; i < 8; i++) qb.push_back({1'b0, 32'hD0 + 32'(i)});
        run(4, 0, 64'h0);
        b_valid = 1; b_data = 32'hD5;
        #1;
        chk("pre_reset_state", {61'h0, o_valid, sel, busy}, 64'h7);
        #2 rst_n = 0;
        #1;
        chk("async_reset_drop", {60'h0, o_valid, sel, busy, b_ready}, 64'h0);
        chk("async_reset_data", {31'h0, o_last, o_data}, 64'h0);
        b_valid = 0;
        @(negedge clk); rst_n = 1;
        clear_q();
        qa.push_back({1'b1, 32'hE0});
        qb.push_back({1'b1, 32'hF0});
        run(6, 0, 64'h0);
        if (so.size() > 0) chk("post_reset_first_grant", {63'h0, so[0]}, 64'h0);
        else chk("post_reset_first_grant", 64'hFFFF, 64'h0);
        if (qo.size() > 0) chk("post_reset_first_beat", {31'h0, qo[0]}, {31'h0, 1'b1, 32'hE0});
        else chk("post_reset_first_beat", 64'hFFFF, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
